wide_comp_ctrl: RTL

- Initiator side of the compare-request handshake (start_cmp / done_cmp / are_equal) served by the bit-serial word comparator.
- Accepts two wide operands of WORD_COUNT words and issues one compare request per word to an external comparator, most-significant word first.
- Stops at the first mismatch and reports the overall equality result and the index of the mismatching word.
- Used by the RSA datapath for loop-termination checks on multi-word values.

---
 rtl/wide_comp_ctrl_if.sv | 42 ++++
 rtl/wide_comp_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wide_comp_ctrl_if.sv
// Bundle between a wide-compare user, the wide_comp_ctrl initiator and the word comparator.
// Optional macro: CMP_TIMEOUT_EN adds the timeout flag.
interface wide_comp_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_COUNT = 4
);
    localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    logic                             ce;
    logic                             start;
    logic [DATA_WIDTH*WORD_COUNT-1:0] a;
    logic [DATA_WIDTH*WORD_COUNT-1:0] b;
    logic                             busy;
    logic                             done;
    logic                             equal;
    logic [IDX_W-1:0]                 mismatch_idx;
`ifdef CMP_TIMEOUT_EN
    logic                             timeout;
`endif
    logic                             cmp_start;
    logic [DATA_WIDTH-1:0]            cmp_in0;
    logic [DATA_WIDTH-1:0]            cmp_in1;
    logic                             cmp_done;
    logic                             cmp_equal;
    logic [1:0]                       state_dbg;

    modport slave (
        input  ce, start, a, b, cmp_done, cmp_equal,
        output busy, done, equal, mismatch_idx, cmp_start, cmp_in0, cmp_in1, state_dbg
`ifdef CMP_TIMEOUT_EN
        , output timeout
`endif
    );

    modport master (
        output ce, start, a, b, cmp_done, cmp_equal,
        input  busy, done, equal, mismatch_idx, cmp_start, cmp_in0, cmp_in1, state_dbg
`ifdef CMP_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/wide_comp_ctrl.sv
// Multi-word compare initiator: feeds operand words MSW-first to an external word comparator
// and stops at the first mismatch. Optional macro: CMP_TIMEOUT_EN (bounded wait per request).
module wide_comp_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int WORD_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic             clk,
    input logic             rst,
    wide_comp_ctrl_if.slave bus
);
    localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int OP_W  = DATA_WIDTH * WORD_COUNT;
    localparam logic [IDX_W-1:0] IDX_MSW = IDX_W'(WORD_COUNT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Handshakes: start is taken only in IDLE with ce=1; done pulses for the FINISH cycle.
    // cmp_start is a request held while in ISSUE (stretched by ce=0); cmp_done/cmp_equal
    // are sampled only in WAIT, so stray completions in any other state are dropped.
    logic [1:0]            state_q, state_d;
    logic [OP_W-1:0]       a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_dec;
    logic [IDX_W-1:0]      mis_q, mis_d;
    logic                  equal_q, equal_d;
    logic [DATA_WIDTH-1:0] in0_q, in0_d, in1_q, in1_d;

`ifdef CMP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    function automatic logic [DATA_WIDTH-1:0] word_of(input logic [OP_W-1:0] op,
                                                      input logic [IDX_W-1:0] i);
        return op[int'(i) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign idx_dec = idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        equal_d = equal_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
`ifdef CMP_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        idx_d   = IDX_MSW;
                        equal_d = 1'b0;
                        mis_d   = '0;
                        in0_d   = word_of(bus.a, IDX_MSW);
                        in1_d   = word_of(bus.b, IDX_MSW);
`ifdef CMP_TIMEOUT_EN
                        tmo_d   = 1'b0;
`endif
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef CMP_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.cmp_done) begin
                        if (!bus.cmp_equal) begin
                            equal_d = 1'b0;
                            mis_d   = idx_q;
                            state_d = S_FINISH;
                        end else if (idx_q == '0) begin
                            equal_d = 1'b1;
                            mis_d   = '0;
                            state_d = S_FINISH;
                        end else begin
                            // Next word is loaded here so cmp_in is valid throughout ISSUE.
                            idx_d   = idx_dec;
                            in0_d   = word_of(a_q, idx_dec);
                            in1_d   = word_of(b_q, idx_dec);
                            state_d = S_ISSUE;
                        end
                    end
`ifdef CMP_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d   = 1'b1;
                        equal_d = 1'b0;
                        mis_d   = idx_q;
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_MSW;
            mis_q   <= '0;
            equal_q <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
`ifdef CMP_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            equal_q <= equal_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
`ifdef CMP_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.done         = (state_q == S_FINISH);
    assign bus.cmp_start    = (state_q == S_ISSUE);
    assign bus.equal        = equal_q;
    assign bus.mismatch_idx = mis_q;
    assign bus.cmp_in0      = in0_q;
    assign bus.cmp_in1      = in1_q;
    assign bus.state_dbg    = state_q;
`ifdef CMP_TIMEOUT_EN
    assign bus.timeout      = tmo_q;
`endif
endmodule
